// File: rtl/jtag_uart_console_if.sv
// Avalon-MM bus between the console master and the Qsys jtag_uart slave port.
// Signal names map 1:1 onto the jtag_uart slave so the top level can wire them straight through.
interface jtag_uart_console_if;
   logic        uart_chipselect;
   logic        uart_address;
   logic        uart_read_n;
   logic        uart_write_n;
   logic [31:0] uart_writedata;
   logic [31:0] uart_readdata;
   logic        uart_waitrequest;

   modport master (
      output uart_chipselect,
      output uart_address,
      output uart_read_n,
      output uart_write_n,
      output uart_writedata,
      input  uart_readdata,
      input  uart_waitrequest
   );

   modport slave (
      input  uart_chipselect,
      input  uart_address,
      input  uart_read_n,
      input  uart_write_n,
      input  uart_writedata,
      output uart_readdata,
      output uart_waitrequest
   );
endinterface

// File: rtl/jtag_uart_console.sv
// Polling Avalon-MM master for the jtag_uart slave. Presents the UART to the core as a TX byte
// stream (core -> host) and an RX byte stream (host -> core). TX bytes are only written after a
// CONTROL read reports free space; RX is polled by DATA reads, spaced by POLL_GAP when empty.
module jtag_uart_console #(
   parameter int unsigned POLL_GAP = 16
) (
   input  logic                       clk_clk,
   input  logic                       reset_reset_n,
   input  logic                       tx_valid,
   input  logic [7:0]                 tx_data,
   output logic                       tx_ready,
   output logic                       rx_valid,
   output logic [7:0]                 rx_data,
   input  logic                       rx_ready,
   jtag_uart_console_if.master        uart
);

   localparam logic [15:0] PollGapCnt = 16'(POLL_GAP);

   typedef enum logic [1:0] {
      StIdle,
      StCtrlRd,
      StDataWr,
      StDataRd
   } state_e;

   state_e      state_q;
   logic [15:0] gap_cnt_q;
   logic        rx_full_q;
   logic [7:0]  rx_hold_q;
   logic        last_tx_q;   // 1: last grant went to TX, 0: to RX

   logic bus_done;
   logic tx_elig;
   logic rx_elig;
   logic grant_tx;
   logic grant_rx;
   logic rx_pop;

   // Bits of DATA read that carry nothing this block needs.
   logic unused_readdata;
   assign unused_readdata = ^uart.uart_readdata[14:8];

   // Arbitration: single requester wins outright; on a tie the side not granted last time wins.
   always_comb begin
      bus_done = !uart.uart_waitrequest;
      tx_elig  = tx_valid;
      rx_elig  = !rx_full_q && (gap_cnt_q == 16'd0);
      grant_tx = tx_elig && (!rx_elig || !last_tx_q);
      grant_rx = rx_elig && (!tx_elig || last_tx_q);
      rx_pop   = rx_full_q && rx_ready;
   end

   // Transaction sequencer plus RX holding register and empty-poll gap counter.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         state_q   <= StIdle;
         gap_cnt_q <= 16'd0;
         rx_full_q <= 1'b0;
         rx_hold_q <= 8'd0;
         last_tx_q <= 1'b0;
      end else begin
         if (gap_cnt_q != 16'd0) begin
            gap_cnt_q <= gap_cnt_q - 16'd1;
         end
         // A fill can't coincide with a pop: DATA_RD is only entered with rx_full_q clear.
         if (rx_pop) begin
            rx_full_q <= 1'b0;
         end
         case (state_q)
            StIdle: begin
               if (grant_tx) begin
                  state_q   <= StCtrlRd;
                  last_tx_q <= 1'b1;
               end else if (grant_rx) begin
                  state_q   <= StDataRd;
                  last_tx_q <= 1'b0;
               end
            end
            StCtrlRd: begin
               if (bus_done) begin
                  // No WSPACE: leave the byte pending and go back through arbitration.
                  state_q <= (uart.uart_readdata[31:16] != 16'd0) ? StDataWr : StIdle;
               end
            end
            StDataWr: begin
               if (bus_done) begin
                  state_q <= StIdle;
               end
            end
            StDataRd: begin
               if (bus_done) begin
                  state_q <= StIdle;
                  if (uart.uart_readdata[15]) begin
                     rx_hold_q <= uart.uart_readdata[7:0];
                     rx_full_q <= 1'b1;
                  end else begin
                     gap_cnt_q <= PollGapCnt;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // Bus strobes decode directly from the state register, so they hold through waitrequest.
   always_comb begin
      uart.uart_chipselect = 1'b0;
      uart.uart_address    = 1'b0;
      uart.uart_read_n     = 1'b1;
      uart.uart_write_n    = 1'b1;
      uart.uart_writedata  = 32'd0;
      case (state_q)
         StCtrlRd: begin
            uart.uart_chipselect = 1'b1;
            uart.uart_address    = 1'b1;
            uart.uart_read_n     = 1'b0;
         end
         StDataWr: begin
            uart.uart_chipselect = 1'b1;
            uart.uart_write_n    = 1'b0;
            uart.uart_writedata  = {24'd0, tx_data};
         end
         StDataRd: begin
            uart.uart_chipselect = 1'b1;
            uart.uart_read_n     = 1'b0;
         end
         default: ;
      endcase
   end

   // Stream side: tx_ready only in the completing DATA_WR cycle; RX straight from the hold reg.
   always_comb begin
      tx_ready = (state_q == StDataWr) && !uart.uart_waitrequest;
      rx_valid = rx_full_q;
      rx_data  = rx_hold_q;
   end

endmodule

// File: tb/tb_jtag_uart_console.sv
// Directed bench for jtag_uart_console with a behavioural jtag_uart slave model and
// scoreboards for TX write data and RX delivered bytes.
module tb_jtag_uart_console;

   localparam int GAP   = 4;
   localparam int KCtrl = 0;
   localparam int KWr   = 1;
   localparam int KRd   = 2;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       tx_valid;
   logic [7:0] tx_data;
   logic       tx_ready;
   logic       rx_valid;
   logic [7:0] rx_data;
   logic       rx_ready;

   jtag_uart_console_if bus ();

   jtag_uart_console #(.POLL_GAP(GAP)) dut (
      .clk_clk       (clk),
      .reset_reset_n (rst_n),
      .tx_valid      (tx_valid),
      .tx_data       (tx_data),
      .tx_ready      (tx_ready),
      .rx_valid      (rx_valid),
      .rx_data       (rx_data),
      .rx_ready      (rx_ready),
      .uart          (bus.master)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Slave model state and observation log.
   int          cyc = 0;
   int          stall_cfg = 0;
   int          stall_age = 0;
   int          stall_seen = 0;
   int          cur_start = 0;
   logic [35:0] snap;
   logic [15:0] wspace_dflt = 16'd64;
   logic [15:0] wspace_seq[$];
   logic [7:0]  rx_chars[$];
   logic [7:0]  tx_exp[$];
   logic [7:0]  rx_exp[$];
   int          ev_kind[$];
   int          ev_start[$];
   int          ev_end[$];
   int          tx_ready_cnt = 0;
   int          wr_cnt = 0;
   int          proto_viol = 0;
   int          stab_viol = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Slave model: drives waitrequest/readdata for the current cycle and logs completions.
   always @(negedge clk) begin : slave_model
      logic [35:0] now;
      logic [15:0] ws;
      logic [7:0]  exp_b;
      int          kind;
      now = {bus.uart_chipselect, bus.uart_address, bus.uart_read_n, bus.uart_write_n,
             bus.uart_writedata};
      if (!bus.uart_read_n && !bus.uart_write_n) proto_viol++;
      if (!bus.uart_write_n && bus.uart_address) proto_viol++;
      if (bus.uart_chipselect) begin
         if (stall_age == 0) begin
            cur_start = cyc;
            snap      = now;
         end else if (now !== snap) begin
            stab_viol++;
         end
         ws = (wspace_seq.size() > 0) ? wspace_seq[0] : wspace_dflt;
         if (bus.uart_address) bus.uart_readdata = {ws, 16'h0};
         else if (rx_chars.size() > 0)
            bus.uart_readdata = {16'(rx_chars.size()), 1'b1, 7'h0, rx_chars[0]};
         else bus.uart_readdata = 32'd0;
         if (stall_age < stall_cfg) begin
            bus.uart_waitrequest = 1'b1;
            stall_age++;
            stall_seen++;
         end else begin
            bus.uart_waitrequest = 1'b0;
            stall_age = 0;
            kind = !bus.uart_read_n ? (bus.uart_address ? KCtrl : KRd) : KWr;
            ev_kind.push_back(kind);
            ev_start.push_back(cur_start);
            ev_end.push_back(cyc);
            if (kind == KCtrl && wspace_seq.size() > 0) void'(wspace_seq.pop_front());
            if (kind == KRd && rx_chars.size() > 0) void'(rx_chars.pop_front());
            if (kind == KWr) begin
               wr_cnt++;
               exp_b = (tx_exp.size() > 0) ? tx_exp.pop_front() : 8'hxx;
               check("tx_writedata", bus.uart_writedata, {24'd0, exp_b});
            end
         end
      end else begin
         bus.uart_waitrequest = 1'b0;
         bus.uart_readdata    = 32'd0;
         stall_age = 0;
      end
   end

   // Stream monitor, sampled after the slave's waitrequest has settled.
   always @(negedge clk) begin : stream_monitor
      logic [7:0] exp_b;
      #1;
      if (tx_ready) tx_ready_cnt++;
      if (rx_valid && rx_ready) begin
         exp_b = (rx_exp.size() > 0) ? rx_exp.pop_front() : 8'hxx;
         check("rx_data_pop", 32'(rx_data), 32'(exp_b));
      end
   end

   task automatic tick();
      @(negedge clk);
      #2;
   endtask

   task automatic drive_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ev(input int n, input int budget, input string tag);
      int k = 0;
      while (ev_kind.size() < n && k < budget) begin
         tick();
         k++;
      end
      check(tag, 32'(ev_kind.size() >= n), 32'd1);
   endtask

   function automatic int count_kind(input int from, input int kind);
      int c = 0;
      for (int i = from; i < ev_kind.size(); i++) if (ev_kind[i] == kind) c++;
      return c;
   endfunction

   task automatic check_reset_outputs(input string pfx);
      check({pfx, "_cs"},    32'(bus.uart_chipselect), 32'd0);
      check({pfx, "_addr"},  32'(bus.uart_address),    32'd0);
      check({pfx, "_rd_n"},  32'(bus.uart_read_n),     32'd1);
      check({pfx, "_wr_n"},  32'(bus.uart_write_n),    32'd1);
      check({pfx, "_wdata"}, bus.uart_writedata,       32'd0);
      check({pfx, "_txrdy"}, 32'(tx_ready),            32'd0);
      check({pfx, "_rxvld"}, 32'(rx_valid),            32'd0);
      check({pfx, "_rxdat"}, 32'(rx_data),             32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int base;
      int base2;
      int rdy0;
      int wr0;
      int k;
      int ctrl_before_wr;
      int stab0;
      int stall0;
      bit seen_wr;

      rst_n    = 1'b0;
      tx_valid = 1'b0;
      tx_data  = 8'd0;
      rx_ready = 1'b0;

      // Reset with random stream inputs.
      repeat (4) begin
         drive_edge();
         tx_valid = 1'($urandom_range(1, 0));
         tx_data  = 8'($urandom);
         rx_ready = 1'($urandom_range(1, 0));
      end
      tick();
      check_reset_outputs("rst");

      drive_edge();
      tx_valid = 1'b0;
      rx_ready = 1'b0;
      rst_n    = 1'b1;
      tick();
      check("post_release_idle", 32'(bus.uart_chipselect), 32'd0);

      // Empty RX polls spaced GAP+2 apart.
      base = ev_kind.size();
      wait_ev(base + 2, 40, "rx_poll_wait");
      check("rx_poll0_kind", 32'(ev_kind[base]), 32'(KRd));
      check("rx_poll1_kind", 32'(ev_kind[base + 1]), 32'(KRd));
      check("rx_poll_spacing", 32'(ev_start[base + 1] - ev_start[base]), 32'(GAP + 2));

      // TX zero wait, launched right after an empty poll completed.
      base = ev_kind.size();
      wait_ev(base + 1, 40, "tx_pre_poll_wait");
      drive_edge();
      tx_valid = 1'b1;
      tx_data  = 8'h41;
      tx_exp.push_back(8'h41);
      base = ev_kind.size();
      rdy0 = tx_ready_cnt;
      wr0  = wr_cnt;
      k = 0;
      do begin
         tick();
         k++;
      end while (!tx_ready && k < 20);
      check("tx_latency", 32'(k), 32'd3);
      drive_edge();
      tx_valid = 1'b0;
      repeat (10) tick();
      check("tx_ready_once", 32'(tx_ready_cnt - rdy0), 32'd1);
      check("tx_one_write", 32'(wr_cnt - wr0), 32'd1);
      check("tx_seq_ctrl", 32'(ev_kind[base]), 32'(KCtrl));
      check("tx_seq_write", 32'(ev_kind[base + 1]), 32'(KWr));
      check("tx_sb_empty", 32'(tx_exp.size()), 32'd0);

      // TX backpressure: two zero-WSPACE reads, then one slot.
      wspace_seq.push_back(16'd0);
      wspace_seq.push_back(16'd0);
      wspace_seq.push_back(16'd1);
      drive_edge();
      tx_valid = 1'b1;
      tx_data  = 8'h5a;
      tx_exp.push_back(8'h5a);
      base = ev_kind.size();
      rdy0 = tx_ready_cnt;
      wr0  = wr_cnt;
      k = 0;
      do begin
         tick();
         k++;
      end while (!tx_ready && k < 80);
      check("bp_ready_seen", 32'(tx_ready), 32'd1);
      drive_edge();
      tx_valid = 1'b0;
      repeat (10) tick();
      ctrl_before_wr = 0;
      seen_wr = 1'b0;
      for (int i = base; i < ev_kind.size(); i++) begin
         if (ev_kind[i] == KWr) seen_wr = 1'b1;
         if (ev_kind[i] == KCtrl && !seen_wr) ctrl_before_wr++;
      end
      check("bp_ctrl_reads", 32'(ctrl_before_wr), 32'd3);
      check("bp_one_write", 32'(wr_cnt - wr0), 32'd1);
      check("bp_ready_once", 32'(tx_ready_cnt - rdy0), 32'd1);
      check("bp_wspace_used", 32'(wspace_seq.size()), 32'd0);

      // RX byte delivery and hold-off while full.
      rx_chars.push_back(8'h48);
      rx_exp.push_back(8'h48);
      k = 0;
      do begin
         tick();
         k++;
      end while (!rx_valid && k < 30);
      check("rx_valid_up", 32'(rx_valid), 32'd1);
      check("rx_data_val", 32'(rx_data), 32'h48);
      check("rx_valid_latency", 32'(cyc - ev_end[ev_end.size() - 1]), 32'd1);
      base2 = ev_kind.size();
      repeat (20) tick();
      check("rx_no_poll_full", 32'(count_kind(base2, KRd)), 32'd0);
      drive_edge();
      rx_ready = 1'b1;
      drive_edge();
      rx_ready = 1'b0;
      tick();
      check("rx_valid_down", 32'(rx_valid), 32'd0);
      check("rx_sb_empty", 32'(rx_exp.size()), 32'd0);
      base2 = ev_kind.size();
      repeat (20) tick();
      check("rx_poll_resumed", 32'(count_kind(base2, KRd) > 0), 32'd1);

      // Contention with 3 stall cycles per transaction; WSPACE=0 keeps TX pending.
      stall_cfg   = 3;
      wspace_dflt = 16'd0;
      stab0       = stab_viol;
      stall0      = stall_seen;
      drive_edge();
      tx_valid = 1'b1;
      tx_data  = 8'h77;
      base = ev_kind.size();
      wait_ev(base + 6, 200, "cont_wait");
      for (int i = 1; i < 6; i++)
         check($sformatf("cont_alternate_%0d", i),
               32'(ev_kind[base + i] != ev_kind[base + i - 1]), 32'd1);
      check("cont_stalls_seen", 32'(stall_seen > stall0), 32'd1);
      check("cont_stable", 32'(stab_viol - stab0), 32'd0);

      // Reset asserted in the second stall cycle of a transaction.
      k = 0;
      while (!(bus.uart_chipselect && stall_age == 2) && k < 20) begin
         tick();
         k++;
      end
      check("cont_second_stall", 32'(bus.uart_chipselect && stall_age == 2), 32'd1);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midrst");
      tx_valid    = 1'b0;
      stall_cfg   = 0;
      wspace_dflt = 16'd64;
      drive_edge();
      drive_edge();
      rst_n = 1'b1;
      repeat (5) tick();

      check("protocol_clean", 32'(proto_viol), 32'd0);
      check("final_tx_sb", 32'(tx_exp.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
